// File: rtl/log_series_pkg.sv
// Shared definitions for the ln(1+x) series unit: FSM state encoding,
// Q8.8 format constants and the 1/n coefficient ROM contents.
package log_series_pkg;

    localparam int FRAC_BITS = 8;
    localparam logic [15:0] Q88_ONE = 16'h0100;

    // 1/n in Q8.8 for n = 1..8
    localparam logic [15:0] COEF_ROM [1:8] = '{
        16'h0100, 16'h0080, 16'h0055, 16'h0040,
        16'h0033, 16'h002B, 16'h0025, 16'h0020
    };

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_INIT = 3'd1,
        ST_CALC = 3'd2,
        ST_ACC  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

endpackage

// File: rtl/log_series_unit_q88_mult.sv
// Combinational Q8.8 multiply: full 32-bit unsigned product, keep bits [23:8].
module q88_mult
    import log_series_pkg::*;
(
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] p
);

    logic [31:0] prod;
    logic        prod_unused;

    assign prod        = 32'(a) * 32'(b);
    assign p           = prod[FRAC_BITS +: 16];
    // Integer overflow bits and sub-LSB fraction bits are discarded by design
    assign prod_unused = ^{prod[31:24], prod[7:0]};

endmodule

// File: rtl/log_series_unit.sv
// Sequential Q8.8 ln(1+x) calculator using x - x^2/2 + x^3/3 - ...
// Optional early exit on term < eps is enabled by defining LOG_EARLY_EXIT_EN;
// without it eps is ignored and exactly N_TERMS terms are always evaluated.
module log_series_unit
    import log_series_pkg::*;
#(
    parameter int N_TERMS = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] x_in,
    input  logic [7:0]  eps,
    output logic [15:0] result,
    output logic        done,
    output logic        busy,
    output logic        err
);

    state_t      state_reg;
    logic [15:0] x_reg;
    logic [15:0] pw_reg;
    logic [15:0] ans_reg;
    logic [15:0] term_reg;
    logic [3:0]  n_reg;
    logic        err_flag_reg;
    logic [15:0] result_reg;
    logic        err_reg;
    logic        done_reg;

    logic [15:0] coef;
    logic [15:0] coef_term;
    logic [15:0] pw_next;
    logic [15:0] ans_next;
    logic        exit_now;

`ifdef LOG_EARLY_EXIT_EN
    logic [7:0]  eps_reg;
`else
    logic        eps_unused;
    assign eps_unused = ^eps;
`endif

    // Coefficient ROM lookup for the current term index
    always_comb begin
        coef = '0;
        for (int i = 1; i <= 8; i++) begin
            if (n_reg == i[3:0]) begin
                coef = COEF_ROM[i];
            end
        end
    end

    q88_mult u_mult_coef (.a(pw_reg), .b(coef),  .p(coef_term));
    q88_mult u_mult_pow  (.a(pw_reg), .b(x_reg), .p(pw_next));

    // Alternating accumulate and loop-exit decision for the ACC state
    always_comb begin
        ans_next = n_reg[0] ? (ans_reg + term_reg) : (ans_reg - term_reg);
        exit_now = (n_reg == 4'(N_TERMS));
`ifdef LOG_EARLY_EXIT_EN
        if (term_reg < {8'b0, eps_reg}) begin
            exit_now = 1'b1;
        end
`endif
    end

    // Controller and datapath; outputs are loaded on entry to DONE so that
    // result/err are already valid during the done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            x_reg        <= '0;
            pw_reg       <= '0;
            ans_reg      <= '0;
            term_reg     <= '0;
            n_reg        <= '0;
            err_flag_reg <= 1'b0;
            result_reg   <= '0;
            err_reg      <= 1'b0;
            done_reg     <= 1'b0;
`ifdef LOG_EARLY_EXIT_EN
            eps_reg      <= '0;
`endif
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        x_reg     <= x_in;
`ifdef LOG_EARLY_EXIT_EN
                        eps_reg   <= eps;
`endif
                        state_reg <= ST_INIT;
                    end
                end
                ST_INIT: begin
                    ans_reg <= '0;
                    if (x_reg >= Q88_ONE) begin
                        err_flag_reg <= 1'b1;
                        result_reg   <= '0;
                        err_reg      <= 1'b1;
                        done_reg     <= 1'b1;
                        state_reg    <= ST_DONE;
                    end else begin
                        pw_reg       <= x_reg;
                        n_reg        <= 4'd1;
                        err_flag_reg <= 1'b0;
                        state_reg    <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    term_reg  <= coef_term;
                    state_reg <= ST_ACC;
                end
                ST_ACC: begin
                    ans_reg <= ans_next;
                    pw_reg  <= pw_next;
                    if (exit_now) begin
                        result_reg <= ans_next;
                        err_reg    <= err_flag_reg;
                        done_reg   <= 1'b1;
                        state_reg  <= ST_DONE;
                    end else begin
                        n_reg     <= n_reg + 4'd1;
                        state_reg <= ST_CALC;
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign result = result_reg;
    assign err    = err_reg;
    assign done   = done_reg;
    assign busy   = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_log_series_unit.sv
// Directed bench for log_series_unit: vector table of single operations
// plus hand-written reset, busy-restart and held-start sequences.
module tb_log_series_unit;

`ifdef LOG_EARLY_EXIT_EN
    localparam bit EE = 1'b1;
`else
    localparam bit EE = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] x_in;
    logic [7:0]  eps;
    logic [15:0] result;
    logic        done;
    logic        busy;
    logic        err;

    int total;
    int bad;

    log_series_unit #(.N_TERMS(8)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .x_in   (x_in),
        .eps    (eps),
        .result (result),
        .done   (done),
        .busy   (busy),
        .err    (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [15:0] x;
        logic [7:0]  e;
        logic [15:0] res;
        logic        er;
        int          edges;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h", name, act, exp);
        end
    endtask

    // One operation: start sampled at edge 1, count edges until done seen
    task automatic run_op(input logic [15:0] x, input logic [7:0] e,
                          output logic [15:0] r, output logic er,
                          output int edges, output logic busy1, output logic done_after);
        @(negedge clk);
        x_in  = x;
        eps   = e;
        start = 1'b1;
        @(posedge clk);
        edges = 1;
        @(negedge clk);
        start = 1'b0;
        busy1 = busy;
        while (!done && edges < 60) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        r  = result;
        er = err;
        @(negedge clk);
        done_after = done;
    endtask

    initial begin
        logic [15:0] r;
        logic        er;
        int          edges;
        logic        b1;
        logic        da;
        int          dcount;
        int          first_edge;
        int          second_edge;

        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        start = 1'b0;
        x_in  = '0;
        eps   = '0;

        vecs[0] = '{"half_eps10",  16'h0080, 8'h10, EE ? 16'h006A : 16'h0067, 1'b0, EE ? 8 : 18};
        vecs[1] = '{"half_eps04",  16'h0080, 8'h04, 16'h0067, 1'b0, EE ? 12 : 18};
        vecs[2] = '{"half_eps00",  16'h0080, 8'h00, 16'h0067, 1'b0, 18};
        vecs[3] = '{"zero_eps01",  16'h0000, 8'h01, 16'h0000, 1'b0, EE ? 4 : 18};
        vecs[4] = '{"range_0100",  16'h0100, 8'h10, 16'h0000, 1'b1, 2};
        vecs[5] = '{"quarter",     16'h0040, 8'h00, 16'h0039, 1'b0, 18};
        vecs[6] = '{"range_0200",  16'h0200, 8'h00, 16'h0000, 1'b1, 2};
        vecs[7] = '{"clear_err",   16'h0080, 8'h00, 16'h0067, 1'b0, 18};

        #1;
        chk("reset_result", int'(result), 0);
        chk("reset_done",   int'(done),   0);
        chk("reset_busy",   int'(busy),   0);
        chk("reset_err",    int'(err),    0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].x, vecs[i].e, r, er, edges, b1, da);
            $display("op %s x=%04h eps=%02h result=%04h err=%0d edges=%0d",
                     vecs[i].name, vecs[i].x, vecs[i].e, r, er, edges);
            chk({vecs[i].name, "_result"}, int'(r), int'(vecs[i].res));
            chk({vecs[i].name, "_err"},    int'(er), int'(vecs[i].er));
            chk({vecs[i].name, "_edges"},  edges, vecs[i].edges);
            chk({vecs[i].name, "_busy"},   int'(b1), 1);
            chk({vecs[i].name, "_pulse"},  int'(da), 0);
        end

        // Asynchronous reset while in ACC: last result was 0x0067
        @(negedge clk);
        x_in  = 16'h0080;
        eps   = 8'h00;
        start = 1'b1;
        repeat (3) @(posedge clk);
        start = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        $display("op async_reset result=%04h busy=%0d done=%0d err=%0d", result, busy, done, err);
        chk("arst_result", int'(result), 0);
        chk("arst_busy",   int'(busy),   0);
        chk("arst_done",   int'(done),   0);
        @(negedge clk);
        rst_n = 1'b1;
        dcount = 0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            if (done) dcount++;
        end
        chk("arst_no_done", dcount, 0);
        run_op(16'h0080, 8'h10, r, er, edges, b1, da);
        $display("op after_reset result=%04h err=%0d edges=%0d", r, er, edges);
        chk("arst_rerun_result", int'(r), EE ? 16'h006A : 16'h0067);
        chk("arst_rerun_edges",  edges, EE ? 8 : 18);

        // Set a distinct result, then restart attempts while busy are ignored
        run_op(16'h0040, 8'h00, r, er, edges, b1, da);
        chk("prep_result", int'(r), 16'h0039);
        @(negedge clk);
        x_in  = 16'h0080;
        eps   = 8'h00;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("hold_mid_op", int'(result), 16'h0039);
        x_in  = 16'h0040;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        dcount = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (done) begin
                dcount++;
                chk("busy_restart_result", int'(result), 16'h0067);
            end
        end
        $display("op busy_restart dones=%0d result=%04h", dcount, result);
        chk("busy_restart_dones", dcount, 1);
        chk("busy_restart_hold",  int'(result), 16'h0067);

        // Held start with out-of-range x: back-to-back operations every 3 edges
        @(negedge clk);
        x_in  = 16'h0100;
        start = 1'b1;
        first_edge  = 0;
        second_edge = 0;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (done && first_edge == 0) first_edge = c;
            else if (done && second_edge == 0) second_edge = c;
        end
        start = 1'b0;
        $display("op held_start first=%0d second=%0d err=%0d", first_edge, second_edge, err);
        chk("held_first_edge", first_edge, 2);
        chk("held_gap", second_edge - first_edge, 3);
        chk("held_err", int'(err), 1);
        repeat (6) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
